// File: rtl/mult_div_unit_pkg.sv
// Shared md_sel encodings, FSM state type and operation-class helpers for the MD unit.
package mult_div_unit_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned MD_SEL_W = 4;

  // md_sel encodings, kept alongside the gwd_/alu_ selects
  localparam logic [MD_SEL_W-1:0] md_none  = 4'd0;
  localparam logic [MD_SEL_W-1:0] md_mult  = 4'd1;
  localparam logic [MD_SEL_W-1:0] md_multu = 4'd2;
  localparam logic [MD_SEL_W-1:0] md_div   = 4'd3;
  localparam logic [MD_SEL_W-1:0] md_divu  = 4'd4;
  localparam logic [MD_SEL_W-1:0] md_mfhi  = 4'd5;
  localparam logic [MD_SEL_W-1:0] md_mflo  = 4'd6;
  localparam logic [MD_SEL_W-1:0] md_mthi  = 4'd7;
  localparam logic [MD_SEL_W-1:0] md_mtlo  = 4'd8;
  localparam logic [MD_SEL_W-1:0] md_madd  = 4'd9;
  localparam logic [MD_SEL_W-1:0] md_maddu = 4'd10;
  localparam logic [MD_SEL_W-1:0] md_msub  = 4'd11;
  localparam logic [MD_SEL_W-1:0] md_msubu = 4'd12;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Operations that occupy the unit for the multiply latency
  function automatic logic is_mult_class(input logic [MD_SEL_W-1:0] sel);
    return (sel == md_mult)  || (sel == md_multu) ||
           (sel == md_madd)  || (sel == md_maddu) ||
           (sel == md_msub)  || (sel == md_msubu);
  endfunction

  // Operations that occupy the unit for the divide latency
  function automatic logic is_div_class(input logic [MD_SEL_W-1:0] sel);
    return (sel == md_div) || (sel == md_divu);
  endfunction

endpackage

// File: rtl/mult_div_unit_md_calc.sv
// Combinational 64-bit {HI,LO} next-value datapath for multiply/divide/accumulate ops.
module md_calc
  import mult_div_unit_pkg::*;
(
  input  logic [DATA_W-1:0]   d1_i,
  input  logic [DATA_W-1:0]   d2_i,
  input  logic [MD_SEL_W-1:0] md_sel_i,
  input  logic [2*DATA_W-1:0] hilo_i,
  output logic [2*DATA_W-1:0] result_o
);

  logic [2*DATA_W-1:0] a_s, b_s, a_u, b_u;
  logic [2*DATA_W-1:0] prod_s, prod_u;
  logic                a_neg, b_neg;
  logic [DATA_W-1:0]   a_abs, b_abs, q_abs, r_abs, q_s, r_s, q_u, r_u;

  // Sign/zero extension so the low 64 bits of a 64x64 product are the exact product
  assign a_s    = {{DATA_W{d1_i[DATA_W-1]}}, d1_i};
  assign b_s    = {{DATA_W{d2_i[DATA_W-1]}}, d2_i};
  assign a_u    = {{DATA_W{1'b0}}, d1_i};
  assign b_u    = {{DATA_W{1'b0}}, d2_i};
  assign prod_s = a_s * b_s;
  assign prod_u = a_u * b_u;

  // Signed divide through magnitudes: quotient truncates toward zero, remainder takes dividend sign.
  // The INT_MIN / -1 case wraps to INT_MIN with remainder 0.
  assign a_neg = d1_i[DATA_W-1];
  assign b_neg = d2_i[DATA_W-1];
  assign a_abs = a_neg ? (~d1_i + DATA_W'(1)) : d1_i;
  assign b_abs = b_neg ? (~d2_i + DATA_W'(1)) : d2_i;
  assign q_abs = a_abs / b_abs;
  assign r_abs = a_abs % b_abs;
  assign q_s   = (a_neg ^ b_neg) ? (~q_abs + DATA_W'(1)) : q_abs;
  assign r_s   = a_neg ? (~r_abs + DATA_W'(1)) : r_abs;
  assign q_u   = d1_i / d2_i;
  assign r_u   = d1_i % d2_i;

  // Select the next {HI,LO}; divide by zero and non-arithmetic selects keep the current value
  always_comb begin
    result_o = hilo_i;
    case (md_sel_i)
      md_mult:  result_o = prod_s;
      md_multu: result_o = prod_u;
      md_div:   if (d2_i != '0) result_o = {r_s, q_s};
      md_divu:  if (d2_i != '0) result_o = {r_u, q_u};
      md_madd:  result_o = hilo_i + prod_s;
      md_maddu: result_o = hilo_i + prod_u;
      md_msub:  result_o = hilo_i - prod_s;
      md_msubu: result_o = hilo_i - prod_u;
      default:  result_o = hilo_i;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit: HI/LO registers, busy FSM with latency counter, mfhi/mflo read port.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   d1,
  input  logic [DATA_W-1:0]   d2,
  input  logic [MD_SEL_W-1:0] md_sel,
  output logic                md_stall,
  output logic [DATA_W-1:0]   md_out
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [2*DATA_W-1:0] res_q, res_d;
  logic [2*DATA_W-1:0] calc_res;
  logic                start_c;
  logic                busy_c;

  md_calc u_md_calc (
    .d1_i     (d1),
    .d2_i     (d2),
    .md_sel_i (md_sel),
    .hilo_i   ({hi_q, lo_q}),
    .result_o (calc_res)
  );

  // Start decode, stall and read port (combinational by definition of the pipeline interface)
  always_comb begin
    busy_c   = (state_q == ST_BUSY);
    start_c  = !busy_c && (is_mult_class(md_sel) || is_div_class(md_sel));
    md_stall = start_c || busy_c;
    case (md_sel)
      md_mfhi: md_out = hi_q;
      md_mflo: md_out = lo_q;
      default: md_out = '0;
    endcase
  end

  // Next-state: latch result on start, count down while busy, commit to HI/LO at count 1
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          res_d   = calc_res;
          state_d = ST_BUSY;
          cnt_d   = is_div_class(md_sel) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (md_sel == md_mthi) begin
          hi_d = d1;
        end else if (md_sel == md_mtlo) begin
          lo_d = d1;
        end
      end
      ST_BUSY: begin
        if (cnt_q <= CNT_W'(1)) begin
          hi_d    = res_q[2*DATA_W-1:DATA_W];
          lo_d    = res_q[DATA_W-1:0];
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset that aborts any in-flight operation
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, arithmetic results, read-during-busy and reset abort.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic [31:0] d1;
  logic [31:0] d2;
  logic [3:0]  md_sel;
  logic        md_stall;
  logic [31:0] md_out;

  int n_cmp;
  int n_mis;
  int ncyc;

  mult_div_unit #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .d1       (d1),
    .d2       (d2),
    .md_sel   (md_sel),
    .md_stall (md_stall),
    .md_out   (md_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op and count cycles with md_stall high (bounded)
  task automatic run_op(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                        output int n);
    md_sel = sel;
    d1     = a;
    d2     = b;
    n      = 0;
    #1;
    while (md_stall && n < 100) begin
      n++;
      tick();
      md_sel = 4'd0;
      #1;
    end
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    md_sel = 4'd5;
    #1;
    chk({tag, "_hi"}, md_out, exp_hi);
    md_sel = 4'd6;
    #1;
    chk({tag, "_lo"}, md_out, exp_lo);
    md_sel = 4'd0;
    #1;
  endtask

  task automatic move_to(input logic [3:0] sel, input logic [31:0] val);
    md_sel = sel;
    d1     = val;
    #1;
    chk("mt_no_stall", {31'd0, md_stall}, 32'd0);
    tick();
    md_sel = 4'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_cmp  = 0;
    n_mis  = 0;
    reset  = 1'b1;
    d1     = '0;
    d2     = '0;
    md_sel = 4'd0;
    tick();
    tick();
    reset = 1'b0;
    #1;

    // Reset state
    chk("rst_stall", {31'd0, md_stall}, 32'd0);
    chk("rst_out", md_out, 32'd0);
    read_hilo("rst", 32'd0, 32'd0);

    // mult -1 * 2
    run_op(4'd1, 32'hFFFF_FFFF, 32'd2, ncyc);
    chk("mult_stall_cycles", 32'(ncyc), 32'd6);
    read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);

    // multu 0xFFFFFFFF * 2
    run_op(4'd2, 32'hFFFF_FFFF, 32'd2, ncyc);
    chk("multu_stall_cycles", 32'(ncyc), 32'd6);
    read_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);

    // div -7 / 2 -> q=-3, r=-1
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, ncyc);
    chk("div_stall_cycles", 32'(ncyc), 32'd11);
    read_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // divu 7 / 0 -> full busy period, HI/LO unchanged
    run_op(4'd4, 32'd7, 32'd0, ncyc);
    chk("divu0_stall_cycles", 32'(ncyc), 32'd11);
    read_hilo("divu0", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // mthi 0, mtlo 5, then msubu 3*2 -> 5 - 6 = -1
    move_to(4'd7, 32'd0);
    move_to(4'd8, 32'd5);
    read_hilo("mt", 32'd0, 32'd5);
    run_op(4'd12, 32'd3, 32'd2, ncyc);
    chk("msubu_stall_cycles", 32'(ncyc), 32'd6);
    read_hilo("msubu", 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // maddu 1*1 wraps {HI,LO} to zero
    run_op(4'd10, 32'd1, 32'd1, ncyc);
    read_hilo("maddu", 32'd0, 32'd0);

    // Signed madd/msub on a fresh base: 10 + (-2*3) = 4, then 4 - (-1*-1) = 3
    move_to(4'd8, 32'd10);
    run_op(4'd9, 32'hFFFF_FFFE, 32'd3, ncyc);
    read_hilo("madd", 32'd0, 32'd4);
    run_op(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ncyc);
    read_hilo("msub", 32'd0, 32'd3);

    // mflo during busy: stall held, old LO visible until commit at 5th edge after start
    md_sel = 4'd1;
    d1     = 32'd3;
    d2     = 32'd4;
    tick();
    md_sel = 4'd6;
    d1     = 32'hDEAD_BEEF;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("mflo_busy_stall", {31'd0, md_stall}, 32'd1);
      chk("mflo_busy_old", md_out, 32'd3);
      if (k < 4) tick();
    end
    tick();
    #1;
    chk("mflo_done_stall", {31'd0, md_stall}, 32'd0);
    chk("mflo_done_new", md_out, 32'd12);
    md_sel = 4'd0;
    read_hilo("mflo_mult", 32'd0, 32'd12);

    // Reset on the 3rd busy cycle of a divide aborts it
    md_sel = 4'd3;
    d1     = 32'd100;
    d2     = 32'd7;
    tick();
    md_sel = 4'd0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("abort_stall", {31'd0, md_stall}, 32'd0);
    read_hilo("abort", 32'd0, 32'd0);
    run_op(4'd1, 32'd5, 32'd6, ncyc);
    chk("post_abort_stall_cycles", 32'(ncyc), 32'd6);
    read_hilo("post_abort", 32'd0, 32'd30);

    // Unused select behaves as none
    md_sel = 4'd13;
    #1;
    chk("sel13_stall", {31'd0, md_stall}, 32'd0);
    chk("sel13_out", md_out, 32'd0);
    md_sel = 4'd0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
